// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7O1 serial receiver: FSM state codes, bit-rate
// divisor selection, frame widths and the odd-parity check.
package rx_serial_pkg;

   localparam int DATA_BITS  = 7;
   localparam int FRAME_BITS = 10;

   typedef enum logic [3:0] {
      INICIAL  = 4'd0,
      ESPERA   = 4'd1,
      START    = 4'd2,
      DADOS    = 4'd3,
      PARIDADE = 4'd4,
      STOP     = 4'd5,
      FINAL    = 4'd6
   } estado_t;

   // Clock cycles per bit at 50 MHz; anything other than 115200 falls back to 9600.
   function automatic int contagem_tick(input int baud);
      return (baud == 115200) ? 434 : 5208;
   endfunction

   // True when data plus parity carry an odd number of ones.
   function automatic logic paridade_impar_ok(input logic [DATA_BITS-1:0] dados,
                                              input logic paridade);
      return ^{dados, paridade};
   endfunction

endpackage

// File: rtl/rx_serial_7o1_fd.sv
// Datapath of the 7O1 receiver: bit-time tick counter, bit counter, shift
// register, parity/stop sample registers and the status/output registers.
module rx_serial_7o1_fd
   import rx_serial_pkg::*;
#(
   parameter int CONTAGEM_TICK = 5208,
   parameter int MEIO_TICK     = 2604
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       serial,
   input  logic       zera_tick,
   input  logic       conta_tick,
   input  logic       zera_bit,
   input  logic       amostra_dado,
   input  logic       amostra_paridade,
   input  logic       amostra_stop,
   input  logic       atualiza,
   input  logic       recebe,
   output logic       fim_tick,
   output logic       meio_tick,
   output logic       fim_bit,
   output logic [6:0] dados_ascii,
   output logic       pronto,
   output logic       tem_dado,
   output logic       erro_paridade,
   output logic       erro_stop,
   output logic       erro_overrun
);

   localparam int TW = $clog2(CONTAGEM_TICK);

   logic [TW-1:0]          tick;
   logic [2:0]             bit_cnt;
   logic [DATA_BITS-1:0]   shift_reg;
   logic                   bit_paridade;
   logic                   bit_stop;

   assign fim_tick  = (tick == TW'(CONTAGEM_TICK - 1));
   assign meio_tick = (tick == TW'(MEIO_TICK - 1));
   assign fim_bit   = (bit_cnt == 3'd6);

   always_ff @(posedge clock) begin
      if (!reset)
         tick <= '0;
      else if (zera_tick)
         tick <= '0;
      else if (conta_tick)
         tick <= tick + 1'b1;
   end

   // Bit counter parks at 6 after the last data bit; it is cleared while idle.
   always_ff @(posedge clock) begin
      if (!reset)
         bit_cnt <= '0;
      else if (zera_bit)
         bit_cnt <= '0;
      else if (amostra_dado && !fim_bit)
         bit_cnt <= bit_cnt + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (amostra_dado)
         shift_reg[bit_cnt] <= serial;
      if (amostra_paridade)
         bit_paridade <= serial;
      if (amostra_stop)
         bit_stop <= serial;
   end

   // A completed frame always wins over a same-cycle acknowledge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         dados_ascii   <= '0;
         pronto        <= 1'b0;
         tem_dado      <= 1'b0;
         erro_paridade <= 1'b0;
         erro_stop     <= 1'b0;
         erro_overrun  <= 1'b0;
      end else begin
         pronto <= atualiza;
         if (atualiza) begin
            dados_ascii   <= shift_reg;
            erro_paridade <= ~paridade_impar_ok(shift_reg, bit_paridade);
            erro_stop     <= ~bit_stop;
            erro_overrun  <= tem_dado;
            tem_dado      <= 1'b1;
         end else if (recebe) begin
            tem_dado <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 UART receiver top: receive FSM plus datapath instance.
// Define RX_SYNC_EN to insert a 2-flop synchronizer on dado_serial (+2 cycles latency).
module rx_serial_7o1
   import rx_serial_pkg::*;
#(
   parameter int BAUD_RATE = 9600
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       dado_serial,
   input  logic       recebe,
   output logic [6:0] dados_ascii,
   output logic       pronto,
   output logic       tem_dado,
   output logic       erro_paridade,
   output logic       erro_stop,
   output logic       erro_overrun,
   output logic [3:0] db_estado
);

   localparam int CONTAGEM_TICK = contagem_tick(BAUD_RATE);
   localparam int MEIO_TICK     = CONTAGEM_TICK / 2;

   estado_t estado, prox;
   logic    linha;
   logic    zera_tick, conta_tick, zera_bit;
   logic    amostra_dado, amostra_paridade, amostra_stop, atualiza;
   logic    fim_tick, meio_tick, fim_bit;

`ifdef RX_SYNC_EN
   logic sinc_a, sinc_b;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sinc_a <= 1'b1;
         sinc_b <= 1'b1;
      end else begin
         sinc_a <= dado_serial;
         sinc_b <= sinc_a;
      end
   end

   assign linha = sinc_b;
`else
   assign linha = dado_serial;
`endif

   always_ff @(posedge clock) begin
      if (!reset)
         estado <= INICIAL;
      else
         estado <= prox;
   end

   always_comb begin
      prox = estado;
      case (estado)
         INICIAL:  prox = ESPERA;
         ESPERA:   if (!linha) prox = START;
         START:    if (meio_tick) prox = linha ? ESPERA : DADOS;
         DADOS:    if (fim_tick && fim_bit) prox = PARIDADE;
         PARIDADE: if (fim_tick) prox = STOP;
         STOP:     if (fim_tick) prox = FINAL;
         FINAL:    prox = ESPERA;
         default:  prox = INICIAL;
      endcase
   end

   // The tick counter restarts at every sample point so each sample lands mid-bit.
   always_comb begin
      zera_tick        = 1'b0;
      conta_tick       = 1'b0;
      zera_bit         = 1'b0;
      amostra_dado     = 1'b0;
      amostra_paridade = 1'b0;
      amostra_stop     = 1'b0;
      atualiza         = 1'b0;
      case (estado)
         INICIAL, ESPERA: begin
            zera_tick = 1'b1;
            zera_bit  = 1'b1;
         end
         START: begin
            zera_tick  = meio_tick;
            conta_tick = ~meio_tick;
         end
         DADOS: begin
            amostra_dado = fim_tick;
            zera_tick    = fim_tick;
            conta_tick   = ~fim_tick;
         end
         PARIDADE: begin
            amostra_paridade = fim_tick;
            zera_tick        = fim_tick;
            conta_tick       = ~fim_tick;
         end
         STOP: begin
            amostra_stop = fim_tick;
            zera_tick    = fim_tick;
            conta_tick   = ~fim_tick;
         end
         FINAL:   atualiza = 1'b1;
         default: zera_tick = 1'b1;
      endcase
   end

   assign db_estado = estado;

   rx_serial_7o1_fd #(
      .CONTAGEM_TICK (CONTAGEM_TICK),
      .MEIO_TICK     (MEIO_TICK)
   ) u_fd (
      .clock            (clock),
      .reset            (reset),
      .serial           (linha),
      .zera_tick        (zera_tick),
      .conta_tick       (conta_tick),
      .zera_bit         (zera_bit),
      .amostra_dado     (amostra_dado),
      .amostra_paridade (amostra_paridade),
      .amostra_stop     (amostra_stop),
      .atualiza         (atualiza),
      .recebe           (recebe),
      .fim_tick         (fim_tick),
      .meio_tick        (meio_tick),
      .fim_bit          (fim_bit),
      .dados_ascii      (dados_ascii),
      .pronto           (pronto),
      .tem_dado         (tem_dado),
      .erro_paridade    (erro_paridade),
      .erro_stop        (erro_stop),
      .erro_overrun     (erro_overrun)
   );

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Bench for rx_serial_7o1 at 115200 baud: frame table plus random frames checked
// against a frame-level model, and hand sequences for false start and mid-frame reset.
module tb_rx_serial_7o1;

   localparam int C = 434;
   localparam int M = 217;
`ifdef RX_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT = M + 9 * C + 2 + SYNC;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       dado_serial = 1'b1;
   logic       recebe = 1'b0;
   logic [6:0] dados_ascii;
   logic       pronto, tem_dado, erro_paridade, erro_stop, erro_overrun;
   logic [3:0] db_estado;

   rx_serial_7o1 #(.BAUD_RATE(115200)) dut (
      .clock         (clock),
      .reset         (reset),
      .dado_serial   (dado_serial),
      .recebe        (recebe),
      .dados_ascii   (dados_ascii),
      .pronto        (pronto),
      .tem_dado      (tem_dado),
      .erro_paridade (erro_paridade),
      .erro_stop     (erro_stop),
      .erro_overrun  (erro_overrun),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   int pcount = 0;
   int pcyc = 0;
   int errors = 0;
   int checks = 0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (pronto) begin
         pcount <= pcount + 1;
         pcyc   <= cyc;
      end
   end

   typedef struct {
      logic [6:0] data;
      logic       par;
      logic       stop;
      logic       ack_before;
      logic       ack_final;
      logic [6:0] exp_data;
      logic       exp_perr;
      logic       exp_serr;
      logic       exp_ovr;
   } vec_t;

   localparam int NV = 10;
   vec_t tab[NV];

   // Frame-level model state
   logic       tem_model;
   logic [6:0] last_data;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic pulse_recebe();
      @(negedge clock) recebe = 1'b1;
      @(negedge clock) recebe = 1'b0;
   endtask

   // Drives one frame from negedge to negedge; optional recebe and reset at given cycle indices.
   task automatic send_frame(input logic [6:0] d, input logic p, input logic s,
                             input int ack_at, input int rst_at, output int n0);
      logic [9:0] fr;
      fr = {s, p, d, 1'b0};
      n0 = 0;
      for (int i = 0; i < 10 * C; i++) begin
         @(negedge clock);
         if (i == 0) n0 = cyc;
         if (rst_at >= 0 && i == rst_at + 1) begin
            reset = 1'b1;
            chk("rst_db_estado", db_estado, 0);
            chk("rst_dados", dados_ascii, 0);
            chk("rst_tem_dado", tem_dado, 0);
            chk("rst_flags", {pronto, erro_paridade, erro_stop, erro_overrun}, 0);
            break;
         end
         if (i % C == 0) dado_serial = fr[i / C];
         recebe = (i == ack_at);
         reset  = (i == rst_at) ? 1'b0 : 1'b1;
      end
      dado_serial = 1'b1;
      recebe = 1'b0;
      reset = 1'b1;
      repeat (C) @(negedge clock);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int pc0, n0, ack_at;
      if (v.ack_before) pulse_recebe();
      ack_at = v.ack_final ? (M + 9 * C + 1 + SYNC) : -1;
      pc0 = pcount;
      send_frame(v.data, v.par, v.stop, ack_at, -1, n0);
      chk($sformatf("v%0d_pronto_count", idx), pcount - pc0, 1);
      chk($sformatf("v%0d_latency", idx), pcyc - n0, LAT);
      chk($sformatf("v%0d_dados", idx), dados_ascii, v.exp_data);
      chk($sformatf("v%0d_erro_paridade", idx), erro_paridade, v.exp_perr);
      chk($sformatf("v%0d_erro_stop", idx), erro_stop, v.exp_serr);
      chk($sformatf("v%0d_erro_overrun", idx), erro_overrun, v.exp_ovr);
      chk($sformatf("v%0d_tem_dado", idx), tem_dado, 1);
      chk($sformatf("v%0d_db_estado", idx), db_estado, 1);
   endtask

   initial begin
      int pc0, n0;
      vec_t v;

      // Directed entries: data, par, stop, ack_before, ack_final, expected data/perr/serr/ovr
      tab[0] = '{7'h41, 1'b1, 1'b1, 1'b1, 1'b0, 7'h41, 1'b0, 1'b0, 1'b0};
      tab[1] = '{7'h43, 1'b0, 1'b1, 1'b1, 1'b0, 7'h43, 1'b0, 1'b0, 1'b0};
      tab[2] = '{7'h43, 1'b1, 1'b1, 1'b1, 1'b0, 7'h43, 1'b1, 1'b0, 1'b0};
      tab[3] = '{7'h41, 1'b1, 1'b0, 1'b1, 1'b0, 7'h41, 1'b0, 1'b1, 1'b0};
      tab[4] = '{7'h41, 1'b1, 1'b1, 1'b1, 1'b0, 7'h41, 1'b0, 1'b0, 1'b0};
      tab[5] = '{7'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 7'h5A, 1'b0, 1'b0, 1'b1};
      tab[6] = '{7'h55, 1'b1, 1'b1, 1'b0, 1'b1, 7'h55, 1'b0, 1'b0, 1'b1};
      tem_model = 1'b0;
      for (int i = 0; i < NV; i++) begin
         if (i >= 7) begin
            tab[i].data       = 7'($urandom);
            tab[i].par        = 1'($urandom);
            tab[i].stop       = ($urandom_range(0, 3) != 0);
            tab[i].ack_before = 1'($urandom);
            tab[i].ack_final  = 1'b0;
            tab[i].exp_data   = tab[i].data;
            tab[i].exp_perr   = (($countones({tab[i].data, tab[i].par}) % 2) == 0);
            tab[i].exp_serr   = !tab[i].stop;
         end
         if (tab[i].ack_before) tem_model = 1'b0;
         if (i >= 7) tab[i].exp_ovr = tem_model;
         tem_model = 1'b1;
      end

      repeat (3) @(negedge clock);
      chk("reset_db_estado", db_estado, 0);
      chk("reset_outputs", {dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, erro_overrun}, 0);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("after_reset_db_estado", db_estado, 1);

      for (int i = 0; i < NV; i++) run_vec(tab[i], i);
      last_data = tab[NV-1].exp_data;

      // False start: line low for 100 cycles, shorter than half a bit.
      pc0 = pcount;
      @(negedge clock) dado_serial = 1'b0;
      repeat (100) @(negedge clock);
      dado_serial = 1'b1;
      repeat (2 * C) @(negedge clock);
      chk("false_start_pronto", pcount - pc0, 0);
      chk("false_start_db_estado", db_estado, 1);
      chk("false_start_dados", dados_ascii, last_data);
      chk("false_start_tem_dado", tem_dado, 1);

      // Reset in the middle of the data bits discards the frame.
      pc0 = pcount;
      send_frame(7'h2A, 1'b0, 1'b1, -1, M + 2 * C + SYNC, n0);
      repeat (C) @(negedge clock);
      chk("abort_pronto", pcount - pc0, 0);
      chk("abort_db_estado", db_estado, 1);

      v = '{7'h30, 1'b1, 1'b1, 1'b0, 1'b0, 7'h30, 1'b0, 1'b0, 1'b0};
      run_vec(v, 99);

      pulse_recebe();
      @(negedge clock);
      chk("recebe_clears", tem_dado, 0);
      pulse_recebe();
      @(negedge clock);
      chk("recebe_idle", tem_dado, 0);
      chk("recebe_keeps_dados", dados_ascii, 7'h30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_serial_7o1.md
Name: rx_serial_7o1

Overview:
- UART receiver for the 7O1 frame format: 1 start bit, 7 data bits sent LSB first, odd parity, 1 stop bit.
- It is the receiving end paired with the team's 7O1 serial transmitter and uses the same BAUD_RATE parameter and the same 50 MHz tick divisors.
- It sits between the GPIO serial input and the game logic, and delivers a 7-bit ASCII character with status flags.

Parameters:
- BAUD_RATE, 9600: line rate. The only legal values are 9600 and 115200.
- CONTAGEM_TICK (localparam), derived: 434 when BAUD_RATE is 115200, otherwise 5208. These are the clock cycles per bit at a 50 MHz clock.
- MEIO_TICK (localparam), derived: CONTAGEM_TICK/2, giving 217 or 2604.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous reset, active-low. Sampled only on the rising edge of clock.
- dado_serial  in  1  serial line. Idles high.
- recebe  in  1  consumer acknowledge. A 1-cycle high clears tem_dado.
- dados_ascii  out  7  last received character. Held stable until the next frame completes.
- pronto  out  1  1-cycle pulse when a frame completes, whether or not it has errors.
- tem_dado  out  1  level. Set together with pronto; cleared by recebe.
- erro_paridade  out  1  the last frame failed the odd-parity check.
- erro_stop  out  1  the stop bit of the last frame was sampled low (framing error).
- erro_overrun  out  1  a frame completed while tem_dado was still 1.
- db_estado  out  4  current FSM state code, for debug.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to INICIAL.
  - Tick counter and bit counter are cleared.
  - dados_ascii=0. pronto, tem_dado and all three error flags are 0.
  - Reset takes effect mid-frame too; the partial frame is discarded.
- FSM states and db_estado codes:
  - INICIAL (0): go to ESPERA on the next cycle.
  - ESPERA (1): idle. Go to START on the first cycle dado_serial==0; clear the tick counter.
  - START (2): count MEIO_TICK cycles, then sample the line.
    - Sample 0: go to DADOS and clear the tick counter.
    - Sample 1: false start. Return to ESPERA with no flags touched.
  - DADOS (3): count CONTAGEM_TICK cycles per bit and sample at each terminal count. The sample is shifted into bit (contagem) of the shift register, LSB first. After 7 samples go to PARIDADE.
  - PARIDADE (4): sample one bit after CONTAGEM_TICK cycles, then go to STOP.
  - STOP (5): sample after CONTAGEM_TICK cycles, then go to FINAL.
  - FINAL (6): the output update happens here, for exactly 1 cycle; then return to ESPERA.
- Output update in FINAL:
  - Shift register is copied to dados_ascii.
  - erro_paridade = NOT(XOR of the 7 data bits and the parity bit). Odd parity means the total count of ones must be odd.
  - erro_stop is set when the stop sample was 0.
  - erro_overrun = tem_dado at that cycle. tem_dado is forced to 1. pronto is 1.
- Every sample point is the mid-bit point of its bit.
- Latency:
  - From the first low cycle seen in ESPERA, pronto rises 2604 + 9×5208 + 2 cycles later (9600 baud).
  - At 115200 baud the figure is 217 + 9×434 + 2 cycles.
- Simultaneous recebe and FINAL: the new frame wins. tem_dado stays 1, and erro_overrun=1 because the previous data was unread.
- recebe while tem_dado==0 has no effect.
- A frame with a framing or parity error still updates dados_ascii and still sets tem_dado.
- Line held low after the stop bit: ESPERA immediately re-enters START. No break detection.
- Counters do not wrap. The tick counter is cleared on every state entry that needs it.
- The bit counter is 3 bits, 0..6. It is checked with ==6 together with the tick terminal count.

Optional Feature:
- Macro RX_SYNC_EN.
  - Defined: dado_serial passes through a 2-flop synchronizer, reset to 1 under reset==0, before the FSM sees it. Every latency above grows by exactly 2 cycles.
  - Undefined: dado_serial feeds the FSM directly. Intended for simulation and for already-synchronized sources.

Decomposition:
- Shared package rx_serial_pkg holds:
  - the state enum and its 4-bit codes;
  - the CONTAGEM_TICK selection function of BAUD_RATE;
  - the 7O1 widths: DATA_BITS=7, FRAME_BITS=10;
  - the odd-parity function.
- One sub-module is natural: rx_serial_7o1_fd. It contains the shift register, the tick counter with terminal count and half-count flags, the bit counter, and the output registers.
- The FSM stays in the top module.

Test Plan:
- Frame 'A' (0x41): data LSB first 1,0,0,0,0,0,1, parity 1, stop 1, at 115200 → pronto pulses once, dados_ascii=0x41, tem_dado=1, all error flags 0.
- Frame 'C' (0x43) with parity bit 0 (correct value is 0, since three ones give odd parity) → erro_paridade=0. Resend with parity 1 → erro_paridade=1, dados_ascii=0x43.
- 'A' frame with stop bit 0 → erro_stop=1, pronto pulses, then FSM returns to ESPERA (db_estado=1).
- Line low for 100 cycles, then high before the mid-start sample at 115200 → no pronto, db_estado back to 1, outputs unchanged.
- Two back-to-back frames 0x41 then 0x5A without recebe → second pronto gives dados_ascii=0x5A and erro_overrun=1. A recebe pulse then gives tem_dado=0.
- reset=0 for 1 cycle during DADOS → next cycle db_estado=0, all outputs 0. A following full 0x30 frame is received correctly.
- Run all of the above with RX_SYNC_EN both defined and undefined. The pronto timestamp must differ by exactly 2 cycles.
